// File: rtl/mac_stream_sequencer_pkg.sv
// Shared types and constants for the MAC stream sequencer and its accumulator bank.
package mac_stream_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LANES = 4;

  // Number of lanes consumed by the next beat given the elements still owed.
  function automatic logic [2:0] beat_lanes(input logic [31:0] rem);
    return (rem >= 32'(LANES)) ? 3'(LANES) : rem[2:0];
  endfunction

endpackage

// File: rtl/mac_stream_sequencer_acc.sv
// Four running sums: cleared at job start, each adds its MAC result on accepted beats.
module mac_acc_bank
  import mac_stream_sequencer_pkg::*;
#(
  parameter int WIDTH_SUM = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [WIDTH_SUM-1:0] add_i [LANES],
  output logic [WIDTH_SUM-1:0] acc_o [LANES]
);

  logic [WIDTH_SUM-1:0] acc_q [LANES];
  logic [WIDTH_SUM-1:0] acc_d [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_acc
    // Plain modular add: overflow wraps, no saturation.
    always_comb begin
      acc_d[gi] = acc_q[gi];
      if (clear_i) begin
        acc_d[gi] = '0;
      end else if (en_i) begin
        acc_d[gi] = acc_q[gi] + add_i[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q[gi] <= '0;
      end else begin
        acc_q[gi] <= acc_d[gi];
      end
    end

    assign acc_o[gi] = acc_q[gi];
  end

endmodule

// File: rtl/mac_stream_sequencer.sv
// Sequencer feeding a 4-neuron MAC stage: counts elements, sets lane-valid, accumulates, hands off sums.
module mac_stream_sequencer
  import mac_stream_sequencer_pkg::*;
#(
  parameter int WIDTH_SUM = 32,
  parameter int WIDTH_A   = 32,
  parameter int WIDTH_B   = 32,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_w0,
  input  logic [WIDTH_B-1:0]   in_w1,
  input  logic [WIDTH_B-1:0]   in_w2,
  input  logic [WIDTH_B-1:0]   in_w3,
  output logic [WIDTH_A-1:0]   mac_a,
  output logic [WIDTH_B-1:0]   mac_w0,
  output logic [WIDTH_B-1:0]   mac_w1,
  output logic [WIDTH_B-1:0]   mac_w2,
  output logic [WIDTH_B-1:0]   mac_w3,
  output logic [2:0]           mac_valid,
  output logic [WIDTH_SUM-1:0] mac_sumin,
  input  logic [WIDTH_SUM-1:0] mac_out0,
  input  logic [WIDTH_SUM-1:0] mac_out1,
  input  logic [WIDTH_SUM-1:0] mac_out2,
  input  logic [WIDTH_SUM-1:0] mac_out3,
  output logic [WIDTH_SUM-1:0] res0,
  output logic [WIDTH_SUM-1:0] res1,
  output logic [WIDTH_SUM-1:0] res2,
  output logic [WIDTH_SUM-1:0] res3,
  output logic                 res_valid,
  input  logic                 res_ready
);

  state_e             state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [LEN_W-1:0]   remaining_d;
  logic               in_ready_q;
  logic               busy_q;
  logic               res_valid_q;
  logic               accept;
  logic               acc_clear;
  logic [WIDTH_SUM-1:0] mac_out_arr [LANES];
  logic [WIDTH_SUM-1:0] acc_arr     [LANES];

  assign mac_a     = in_a;
  assign mac_w0    = in_w0;
  assign mac_w1    = in_w1;
  assign mac_w2    = in_w2;
  assign mac_w3    = in_w3;
  assign mac_sumin = '0;

  assign mac_valid   = (state_q == ST_RUN) ? beat_lanes(32'(remaining_q)) : 3'd0;
  assign accept      = in_valid & in_ready_q;
  assign remaining_d = remaining_q - LEN_W'(mac_valid);
  assign acc_clear   = (state_q == ST_IDLE) & start;

  assign mac_out_arr[0] = mac_out0;
  assign mac_out_arr[1] = mac_out1;
  assign mac_out_arr[2] = mac_out2;
  assign mac_out_arr[3] = mac_out3;

  mac_acc_bank #(.WIDTH_SUM(WIDTH_SUM)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .en_i    (accept),
    .add_i   (mac_out_arr),
    .acc_o   (acc_arr)
  );

  // Control outputs are flops updated alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              remaining_q <= len;
              in_ready_q  <= 1'b1;
              state_q     <= ST_RUN;
            end else begin
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            remaining_q <= remaining_d;
            if (remaining_d == '0) begin
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res0      = acc_arr[0];
  assign res1      = acc_arr[1];
  assign res2      = acc_arr[2];
  assign res3      = acc_arr[3];

endmodule
